// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor port scheduler.
//   LOCAL_WIDTH_DEF : default predictor index width (index = PC[LOCAL_WIDTH+1:2])
//   sched_state_e   : scheduler mode, NORMAL (fetch first) or DRAIN (updates first)
//   upd_entry_t     : one buffered commit outcome {predictor index, taken}
package bp_pkg;

  localparam int LOCAL_WIDTH_DEF = 10;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [LOCAL_WIDTH_DEF-1:0] index;
    logic                       taken;
  } upd_entry_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO holding committed-branch outcomes until the predictor port is free.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   push_i, data_i   : enqueue request and entry (ignored when full)
//   pop_i            : dequeue head (ignored when empty)
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored entries (0..DEPTH)
//   head_o           : oldest entry; only meaningful when !empty_o
module bp_update_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are log2(DEPTH) wide and wrap on their own.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_port_scheduler.sv
// Shares the single address/update port of the branch predictor between fetch lookups
// (latency-critical) and buffered commit-outcome updates (deferrable). NORMAL mode favours
// fetch; DRAIN mode favours updates and is entered on high occupancy or a stale head.
// Ports:
//   clk_in, rst_n_in, rdy_in          : clock, async active-low reset, global freeze when low
//   fetch_req_in/addr_in, fetch_gnt_out : lookup request, PC, combinational grant
//   fetch_pred_valid_out/pred_out     : prediction for the previous cycle's granted lookup
//   commit_valid/addr/taken_in, commit_ready_out : outcome producer handshake
//   pred_addr_out, pred_transition_out, pred_branch_out : predictor index/update strobe/outcome
//   pred_prediction_in                : predictor output for the previous cycle's index
module bp_port_scheduler
  import bp_pkg::*;
#(
  parameter int LOCAL_WIDTH = LOCAL_WIDTH_DEF,
  parameter int DEPTH       = 8,
  parameter int HI_THRESH   = 6,
  parameter int LO_THRESH   = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   fetch_req_in,
  input  logic [31:0]            fetch_addr_in,
  output logic                   fetch_gnt_out,
  output logic                   fetch_pred_valid_out,
  output logic                   fetch_pred_out,
  input  logic                   commit_valid_in,
  input  logic [31:0]            commit_addr_in,
  input  logic                   commit_taken_in,
  output logic                   commit_ready_out,
  output logic [LOCAL_WIDTH-1:0] pred_addr_out,
  output logic                   pred_transition_out,
  output logic                   pred_branch_out,
  input  logic                   pred_prediction_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int EW = $bits(upd_entry_t);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  sched_state_e           state_q, state_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [LOCAL_WIDTH-1:0] last_addr_q;
  logic                   live_q, pv_q, hold_q;

  logic [AW:0]            count;
  logic                   full, empty;
  upd_entry_t             head, push_entry;
  logic [EW-1:0]          head_bits;
  logic                   port_en, gnt, upd, push;
  logic [LOCAL_WIDTH-1:0] fetch_idx;
  logic                   unused_bits;

  assign fetch_idx  = fetch_addr_in[LOCAL_WIDTH+1:2];
  assign push_entry = '{index: commit_addr_in[LOCAL_WIDTH+1:2], taken: commit_taken_in};
  assign head       = upd_entry_t'(head_bits);

  assign commit_ready_out = rdy_in && !full;
  assign push             = commit_valid_in && commit_ready_out;
  // Grants are suppressed while reset is asserted so the port is quiet during reset.
  assign port_en          = rdy_in && rst_n_in;

  assign unused_bits = ^{fetch_addr_in[31:LOCAL_WIDTH+2], fetch_addr_in[1:0],
                         commit_addr_in[31:LOCAL_WIDTH+2], commit_addr_in[1:0]};

  bp_update_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push_i   (push),
    .data_i   (push_entry),
    .pop_i    (upd),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (count),
    .head_o   (head_bits)
  );

  // Port ownership: exactly one of lookup/update per ready cycle, chosen by mode.
  always_comb begin
    gnt = 1'b0;
    upd = 1'b0;
    if (port_en) begin
      case (state_q)
        NORMAL: begin
          gnt = fetch_req_in;
          upd = !fetch_req_in && !empty;
        end
        DRAIN: begin
          upd = !empty;
          gnt = empty && fetch_req_in;
        end
        default: begin
          gnt = 1'b0;
          upd = 1'b0;
        end
      endcase
    end
  end

  // Mode and head-age next state. Entry uses registered occupancy/age; exit looks at the
  // occupancy left after this cycle's pop and push.
  always_comb begin
    logic [AW:0] count_after;
    state_d     = state_q;
    wait_d      = wait_q;
    count_after = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, upd};
    if (port_en) begin
      case (state_q)
        NORMAL: if (int'(count) >= HI_THRESH || wait_q == WAIT_MAX) state_d = DRAIN;
        DRAIN:  if (int'(count_after) <= LO_THRESH) state_d = NORMAL;
        default: state_d = NORMAL;
      endcase
      if (upd || count_after == '0) wait_d = '0;
      else if (wait_q != WAIT_MAX)  wait_d = wait_q + 1'b1;
    end
  end

  assign fetch_gnt_out       = gnt;
  assign pred_transition_out = upd;
  assign pred_branch_out     = upd && head.taken;
  assign pred_addr_out       = gnt ? fetch_idx : (upd ? head.index : last_addr_q);

  // The predictor answers one cycle after it sees the index, so the prediction is passed
  // straight through in the cycle after a grant; otherwise the last shown value is held.
  assign fetch_pred_valid_out = pv_q;
  assign fetch_pred_out       = live_q ? pred_prediction_in : hold_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= NORMAL;
      wait_q      <= '0;
      last_addr_q <= '0;
      live_q      <= 1'b0;
      pv_q        <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      last_addr_q <= pred_addr_out;
      hold_q      <= fetch_pred_out;
      if (rdy_in) begin
        live_q <= gnt;
        pv_q   <= gnt;
      end else begin
        live_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bp_port_scheduler.sv
module tb_bp_port_scheduler;

  localparam int DEPTH = 8;
  localparam int HI    = 6;
  localparam int LO    = 2;
  localparam int MAXW  = 15;
  localparam int LW    = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default thresholds)
  logic          rst_n, rdy, req, cv, ct, pin;
  logic [31:0]   faddr, caddr;
  logic          gnt, pv, pp, cready, trans, br;
  logic [LW-1:0] paddr;

  // second instance with HI_THRESH = DEPTH so the FIFO can actually fill
  logic          f_rst_n, f_req, f_cv, f_ct;
  logic [31:0]   f_caddr;
  logic          f_gnt, f_pv, f_pp, f_ready, f_trans, f_br;
  logic [LW-1:0] f_paddr;

  bp_port_scheduler #(.LOCAL_WIDTH(LW), .DEPTH(DEPTH), .HI_THRESH(HI), .LO_THRESH(LO),
                      .MAX_WAIT(MAXW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .fetch_req_in(req), .fetch_addr_in(faddr), .fetch_gnt_out(gnt),
    .fetch_pred_valid_out(pv), .fetch_pred_out(pp),
    .commit_valid_in(cv), .commit_addr_in(caddr), .commit_taken_in(ct),
    .commit_ready_out(cready), .pred_addr_out(paddr), .pred_transition_out(trans),
    .pred_branch_out(br), .pred_prediction_in(pin)
  );

  bp_port_scheduler #(.LOCAL_WIDTH(LW), .DEPTH(DEPTH), .HI_THRESH(DEPTH), .LO_THRESH(LO),
                      .MAX_WAIT(MAXW)) dut_full (
    .clk_in(clk), .rst_n_in(f_rst_n), .rdy_in(1'b1),
    .fetch_req_in(f_req), .fetch_addr_in(32'h0000_0040), .fetch_gnt_out(f_gnt),
    .fetch_pred_valid_out(f_pv), .fetch_pred_out(f_pp),
    .commit_valid_in(f_cv), .commit_addr_in(f_caddr), .commit_taken_in(f_ct),
    .commit_ready_out(f_ready), .pred_addr_out(f_paddr), .pred_transition_out(f_trans),
    .pred_branch_out(f_br), .pred_prediction_in(1'b0)
  );

  typedef struct {
    int cyc;
    bit gnt, trans, ready, pv, pp, br;
    int addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   upd_seen_cyc = -2;

  // Reference model state: the FIFO as a queue of (index*2 + taken) in commit order.
  int mq[$];
  bit drain_m;
  int wait_m, last_m;
  bit live_m, pv_m, pp_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  // Drive one cycle's inputs and record what the scheduler must present in that cycle.
  task automatic step(input bit r, input bit rq, input logic [31:0] fa, input bit c_v,
                      input logic [31:0] c_a, input bit c_t, input bit p_in);
    exp_t e;
    int   cnt, after;
    bit   g, u, push;
    rdy = r; req = rq; faddr = fa; cv = c_v; caddr = c_a; ct = c_t; pin = p_in;
    cnt     = mq.size();
    e.cyc   = cyc;
    e.ready = r && (cnt != DEPTH);
    e.pv    = pv_m;
    e.pp    = live_m ? p_in : pp_m;
    pp_m    = e.pp;
    g = 1'b0;
    u = 1'b0;
    if (r) begin
      if (!drain_m) begin
        g = rq;
        u = !rq && (cnt > 0);
      end else begin
        u = (cnt > 0);
        g = !u && rq;
      end
    end
    e.gnt   = g;
    e.trans = u;
    e.br    = u ? mq[0][0] : 1'b0;
    e.addr  = g ? idx_of(fa) : (u ? (mq[0] >> 1) : last_m);
    last_m  = e.addr;
    if (r) begin
      push = c_v && e.ready;
      if (u) void'(mq.pop_front());
      if (push) mq.push_back(idx_of(c_a) * 2 + (c_t ? 1 : 0));
      after = mq.size();
      if (!drain_m) drain_m = (cnt >= HI) || (wait_m == MAXW);
      else          drain_m = (after > LO);
      wait_m = (u || after == 0) ? 0 : ((wait_m < MAXW) ? wait_m + 1 : MAXW);
      live_m = g;
      pv_m   = g;
    end else begin
      live_m = 1'b0;
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic cstep(input bit r, input bit rq, input logic [31:0] fa, input bit c_v,
                       input logic [31:0] c_a, input bit c_t, input bit p_in);
    @(posedge clk);
    #1;
    step(r, rq, fa, c_v, c_a, c_t, p_in);
  endtask

  // Assert reset mid-cycle with activity on the inputs; everything must clear at once.
  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0; rdy = 1'b1; req = 1'b1; cv = 1'b1; pin = 1'b1;
    mq.delete();
    drain_m = 1'b0; wait_m = 0; last_m = 0; live_m = 1'b0; pv_m = 1'b0; pp_m = 1'b0;
    e.cyc = cyc; e.gnt = 1'b0; e.trans = 1'b0; e.ready = 1'b1;
    e.pv = 1'b0; e.pp = 1'b0; e.br = 1'b0; e.addr = 0;
    exp_q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the queued expectation for the cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk("fetch_gnt", gnt, m_e.gnt);
      chk("pred_transition", trans, m_e.trans);
      chk("commit_ready", cready, m_e.ready);
      chk("fetch_pred_valid", pv, m_e.pv);
      chk("fetch_pred", pp, m_e.pp);
      chk("pred_addr", paddr, m_e.addr);
      if (m_e.trans) chk("pred_branch", br, m_e.br);
      if (trans === 1'b1 && upd_seen_cyc == -1) upd_seen_cyc = m_e.cyc;
    end
  end

  int push_cyc;
  int fq[$];
  int f_pend;

  initial begin
    rst_n = 1'b0; rdy = 1'b0; req = 1'b0; cv = 1'b0; ct = 1'b0; pin = 1'b0;
    faddr = 32'h0; caddr = 32'h0;
    f_rst_n = 1'b0; f_req = 1'b1; f_cv = 1'b0; f_ct = 1'b0; f_caddr = 32'h0;

    do_reset();

    // Lookup of 0x1004 -> index 1, prediction passed through one cycle later.
    cstep(1'b1, 1'b1, 32'h0000_1004, 1'b0, 32'h0, 1'b0, 1'b0);
    cstep(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cstep(1'b1, 1'b1, 32'h0000_1004, 1'b0, 32'h0, 1'b0, 1'b1);
    cstep(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cstep(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Single commit starved by continuous fetch: forced update 16 cycles after the push.
    upd_seen_cyc = -1;
    cstep(1'b1, 1'b1, $urandom(), 1'b1, 32'h0000_2A5C, 1'b1, 1'b0);
    push_cyc = cyc - 1;
    for (int i = 0; i < 20; i++)
      cstep(1'b1, 1'b1, $urandom(), 1'b0, 32'h0, 1'b0, ($urandom_range(0, 1) == 1));
    @(negedge clk);
    #1;
    chk("starved_update_latency", upd_seen_cyc - push_cyc, 16);
    upd_seen_cyc = -2;

    // Six outcomes under continuous fetch: drain entered at 6, exits at 2.
    for (int i = 0; i < 6; i++)
      cstep(1'b1, 1'b1, $urandom(), 1'b1, $urandom(), ($urandom_range(0, 1) == 1), 1'b0);
    for (int i = 0; i < 40; i++)
      cstep(1'b1, 1'b1, $urandom(), 1'b0, 32'h0, 1'b0, ($urandom_range(0, 1) == 1));

    // Freeze: pending update, request and commit all held off for 3 cycles.
    cstep(1'b1, 1'b1, $urandom(), 1'b1, 32'h0000_0F00, 1'b1, 1'b0);
    cstep(1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cstep(1'b0, 1'b1, $urandom(), 1'b1, 32'h0000_0BB8, 1'b0, ($urandom_range(0, 1) == 1));
    for (int i = 0; i < 5; i++)
      cstep(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, ($urandom_range(0, 1) == 1));

    // Reset while five entries are queued.
    for (int i = 0; i < 5; i++)
      cstep(1'b1, 1'b1, $urandom(), 1'b1, $urandom(), ($urandom_range(0, 1) == 1), 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++)
      cstep(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      cstep(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), $urandom(),
            ($urandom_range(0, 1) == 1), $urandom(), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 1) == 1));
    @(negedge clk);

    // Full FIFO on the high-threshold instance: 8 pushes fill it, the 9th waits for a pop.
    @(posedge clk);
    #1;
    f_rst_n = 1'b1;
    f_pend  = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (k < 9) begin
        f_caddr = $urandom();
        f_ct    = ($urandom_range(0, 1) == 1);
        f_cv    = 1'b1;
        f_pend  = idx_of(f_caddr) * 2 + (f_ct ? 1 : 0);
        if (k < 8) fq.push_back(f_pend);
      end else if (k > 10) begin
        f_cv = 1'b0;
      end
      if (k == 10) fq.push_back(f_pend);
      @(negedge clk);
      if (k < 8)            chk("full_ready_before", f_ready, 1);
      if (k == 8 || k == 9) chk("full_ready_low", f_ready, 0);
      if (k == 10)          chk("full_ready_after_pop", f_ready, 1);
      if (f_trans === 1'b1) begin
        chk("full_gnt_during_update", f_gnt, 0);
        if (fq.size() == 0) begin
          chk("full_unexpected_update", 1, 0);
        end else begin
          chk("full_update_index", f_paddr, fq[0] >> 1);
          chk("full_update_taken", f_br, fq[0] & 1);
          void'(fq.pop_front());
        end
      end
    end
    chk("full_all_applied", fq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
